// File: rtl/sample_capture.sv
// Triggered two-channel sample capture buffer with CPU read-back.
// Arm, wait for trigger, store decimated {ch1,ch0} words, then hold in DONE.
module sample_capture #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_ch0,
    input  logic [DW-1:0] in_ch1,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig_mode,
    input  logic [DW-1:0] trig_level,
    input  logic [7:0]    decim,
    input  logic [AW:0]   num_samples,
    input  logic [AW-1:0] rd_addr,
    output logic [2*DW-1:0] rd_data,
    output logic [1:0]    state,
    output logic          done,
    output logic [AW:0]   wr_count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        st;
    logic          cfg_mode;
    logic [DW-1:0] cfg_level;
    logic [7:0]    cfg_decim;
    logic [AW:0]   cfg_count;
    logic [7:0]    dcnt;
    logic          prev_ok;
    logic [DW-1:0] prev_ch0;

    logic [2*DW-1:0] mem [DEPTH];

    logic          trig_hit;
    logic          cap_hit;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW:0]   wr_next;
    logic [AW:0]   count_clamped;

    always_comb begin
        trig_hit = 1'b0;
        if (st == S_ARMED && in_valid) begin
            trig_hit = !cfg_mode ||
                       (prev_ok &&
                        ($signed(prev_ch0) < $signed(cfg_level)) &&
                        ($signed(cfg_level) <= $signed(in_ch0)));
        end
        cap_hit = (st == S_CAPTURE) && in_valid && (dcnt == 8'd0);
        // Control pulses preempt any store in the same cycle
        we      = (trig_hit || cap_hit) && !rst && !abort && !arm;
        waddr   = trig_hit ? '0 : wr_count[AW-1:0];
        wr_next = wr_count + 1'b1;
        count_clamped = num_samples;
        if (num_samples == '0 || num_samples > DEPTH_W)
            count_clamped = DEPTH_W;
    end

    always_ff @(posedge sys_clk) begin
        if (we)
            mem[waddr] <= {in_ch1, in_ch0};
    end

    always_ff @(posedge sys_clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st        <= S_IDLE;
            done      <= 1'b0;
            wr_count  <= '0;
            dcnt      <= '0;
            prev_ok   <= 1'b0;
            prev_ch0  <= '0;
            cfg_mode  <= 1'b0;
            cfg_level <= '0;
            cfg_decim <= '0;
            cfg_count <= DEPTH_W;
        end else if (abort) begin
            st   <= S_IDLE;
            done <= 1'b0;
        end else if (arm) begin
            cfg_mode  <= trig_mode;
            cfg_level <= trig_level;
            cfg_decim <= decim;
            cfg_count <= count_clamped;
            wr_count  <= '0;
            dcnt      <= '0;
            prev_ok   <= 1'b0;
            st        <= S_ARMED;
            done      <= 1'b0;
        end else begin
            unique case (st)
                S_ARMED: begin
                    if (in_valid) begin
                        prev_ch0 <= in_ch0;
                        prev_ok  <= 1'b1;
                        if (trig_hit) begin
                            wr_count <= {{AW{1'b0}}, 1'b1};
                            dcnt     <= cfg_decim;
                            if (cfg_count == {{AW{1'b0}}, 1'b1}) begin
                                st   <= S_DONE;
                                done <= 1'b1;
                            end else begin
                                st <= S_CAPTURE;
                            end
                        end
                    end
                end
                S_CAPTURE: begin
                    if (in_valid) begin
                        if (dcnt == 8'd0) begin
                            wr_count <= wr_next;
                            dcnt     <= cfg_decim;
                            if (wr_next == cfg_count) begin
                                st   <= S_DONE;
                                done <= 1'b1;
                            end
                        end else begin
                            dcnt <= dcnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_sample_capture.sv
// Randomized bench for sample_capture against a
// sample-index reference model of the capture rules.
module tb_sample_capture;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          sys_clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_ch0;
    logic [DW-1:0] in_ch1;
    logic          arm;
    logic          abort;
    logic          trig_mode;
    logic [DW-1:0] trig_level;
    logic [7:0]    decim;
    logic [AW:0]   num_samples;
    logic [AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    state;
    logic          done;
    logic [AW:0]   wr_count;

    sample_capture #(.DW(DW), .AW(AW)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ch0     (in_ch0),
        .in_ch1     (in_ch1),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .decim      (decim),
        .num_samples(num_samples),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .state      (state),
        .done       (done),
        .wr_count   (wr_count)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: counts valid samples since the trigger
    int          m_state;
    int          m_wr;
    bit          m_mode;
    int          m_level;
    int          m_decim;
    int          m_target;
    bit          m_prev_ok;
    int          m_prev;
    int          m_k;
    logic [31:0] m_mem [DEPTH];
    bit          m_memv [DEPTH];
    logic [31:0] m_rd;
    bit          m_rdv;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        logic [31:0] w;
        int c0;
        bit hit;
        w  = {in_ch1, in_ch0};
        c0 = int'($signed(in_ch0));
        if (rst) begin
            m_rd = '0;
            m_rdv = 1'b1;
        end else begin
            m_rd = m_mem[rd_addr];
            m_rdv = m_memv[rd_addr];
        end
        if (rst) begin
            m_state = 0;
            m_wr = 0;
            m_prev_ok = 0;
            return;
        end
        if (abort) begin
            m_state = 0;
            return;
        end
        if (arm) begin
            m_mode   = trig_mode;
            m_level  = int'($signed(trig_level));
            m_decim  = int'(decim);
            m_target = int'(num_samples);
            if (m_target == 0 || m_target > DEPTH)
                m_target = DEPTH;
            m_wr = 0;
            m_prev_ok = 0;
            m_state = 1;
            return;
        end
        if (!in_valid)
            return;
        if (m_state == 1) begin
            hit = !m_mode ||
                  (m_prev_ok && m_prev < m_level && m_level <= c0);
            m_prev = c0;
            m_prev_ok = 1;
            if (hit) begin
                m_mem[0] = w;
                m_memv[0] = 1;
                m_wr = 1;
                m_k = 0;
                m_state = (m_target == 1) ? 3 : 2;
            end
        end else if (m_state == 2) begin
            m_k++;
            if (m_k % (m_decim + 1) == 0) begin
                m_mem[m_wr] = w;
                m_memv[m_wr] = 1;
                m_wr++;
                if (m_wr == m_target)
                    m_state = 3;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge sys_clk);
        #1;
        chk("state", state, m_state);
        chk("done", done, m_state == 3);
        chk("wr_count", wr_count, m_wr);
        if (m_rdv)
            chk("rd_data", rd_data, m_rd);
    endtask

    task automatic do_arm(input bit mode, input int lvl,
                          input int dec, input int ns);
        trig_mode   = mode;
        trig_level  = lvl[15:0];
        decim       = dec[7:0];
        num_samples = ns[10:0];
        in_valid    = 1'b0;
        arm         = 1'b1;
        step();
        arm         = 1'b0;
        trig_mode   = 1'($urandom);
        trig_level  = 16'($urandom);
        decim       = 8'($urandom);
        num_samples = 11'($urandom);
    endtask

    task automatic send(input int c0, input int c1);
        in_valid = 1'b1;
        in_ch0   = c0[15:0];
        in_ch1   = c1[15:0];
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd_at(input int a);
        rd_addr = a[9:0];
        step();
    endtask

    logic [15:0] r8;
    logic [15:0] tmp;
    int v;
    int ch1r;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_ch0 = '0;
        in_ch1 = '0;
        arm = 1'b0;
        abort = 1'b0;
        trig_mode = 1'b0;
        trig_level = '0;
        decim = '0;
        num_samples = '0;
        rd_addr = '0;
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_rd", rd_data, 0);
        rst = 1'b0;
        step();

        // full depth, num_samples 0 then 2000
        do_arm(0, 0, 0, 0);
        for (int i = 0; i < 1030; i++)
            send(i, ~i);
        chk("full0_wr", wr_count, 1024);
        chk("full0_st", state, 3);
        rd_at(1023);
        tmp = 16'd1023;
        chk("full0_last", rd_data, {~tmp, tmp});
        rd_at(0);
        chk("full0_first", rd_data, 32'hFFFF_0000);

        do_arm(0, 0, 0, 2000);
        r8 = '0;
        for (int i = 0; i < 1030; i++) begin
            ch1r = int'($urandom_range(0, 65535));
            if (i == 8)
                r8 = ch1r[15:0];
            send(5000 + i, ch1r);
        end
        chk("full2k_wr", wr_count, 1024);
        rd_at(1023);
        chk("full2k_last", rd_data[15:0], 16'd6023);
        rd_at(0);
        chk("full2k_first", rd_data[15:0], 16'd5000);

        // immediate capture, decim 0
        do_arm(0, 0, 0, 8);
        for (int i = 0; i < 10; i++)
            send(i, 100 + i);
        chk("imm_st", state, 3);
        chk("imm_wr", wr_count, 8);
        for (int i = 0; i < 9; i++) begin
            rd_at(i);
            if (i < 8)
                chk("imm_mem", rd_data, {16'(100 + i), 16'(i)});
            else
                chk("imm_mem8", rd_data, {r8, 16'd5008});
        end

        // level trigger
        do_arm(1, 0, 0, 4);
        send(-5, 1);
        send(-3, 1);
        send(-1, 1);
        chk("lvl_armed", state, 1);
        send(2, 1);
        chk("lvl_trig", state, 2);
        send(4, 1);
        send(6, 1);
        send(8, 1);
        chk("lvl_done", state, 3);
        for (int i = 0; i < 4; i++) begin
            rd_at(i);
            chk("lvl_mem", rd_data[15:0], 16'(2 + 2 * i));
        end
        do_arm(1, 0, 0, 4);
        send(7, 0);
        chk("lvl_first", state, 1);
        send(8, 0);
        chk("lvl_noedge", state, 1);

        // decimation with gaps
        do_arm(0, 0, 2, 3);
        for (int i = 0; i < 10; i++) begin
            send(i, int'($urandom_range(0, 65535)));
            if (i == 5)
                chk("dec_pre", state, 2);
            if (i == 6)
                chk("dec_done", state, 3);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            rd_at(i);
            chk("dec_mem", rd_data[15:0], 16'(3 * i));
        end

        // abort mid-capture
        do_arm(0, 0, 0, 20);
        for (int i = 0; i < 5; i++)
            send(200 + i, 0);
        chk("abt_wr5", wr_count, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abt_idle", state, 0);
        for (int i = 0; i < 3; i++)
            send(300 + i, 0);
        chk("abt_keep", wr_count, 5);
        rd_at(5);
        chk("abt_nowr", rd_data, {16'd105, 16'd5});

        do_arm(0, 0, 0, 20);
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        chk("arm_abt", state, 0);

        do_arm(0, 0, 0, 20);
        for (int i = 0; i < 3; i++)
            send(i, 0);
        chk("rearm_cap", state, 2);
        do_arm(0, 0, 0, 20);
        chk("rearm_st", state, 1);
        chk("rearm_wr", wr_count, 0);

        // reset mid-capture
        for (int i = 0; i < 4; i++)
            send(400 + i, 0);
        rd_addr = 10'd3;
        rst = 1'b1;
        step();
        chk("rstc_state", state, 0);
        chk("rstc_done", done, 0);
        chk("rstc_rd", rd_data, 0);
        rst = 1'b0;
        step();
        chk("rstc_mem3", rd_data[15:0], 16'd403);

        // randomized sessions
        for (int t = 0; t < 40; t++) begin
            v = int'($urandom_range(0, 40)) - 20;
            do_arm(1'($urandom_range(0, 1)), v,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 12)));
            for (int c = 0; c < 60; c++) begin
                v = int'($urandom_range(0, 60)) - 30;
                in_valid = ($urandom_range(0, 2) != 0);
                in_ch0 = v[15:0];
                in_ch1 = 16'($urandom);
                rd_addr = 10'($urandom_range(0, 31));
                abort = ($urandom_range(0, 99) == 0);
                arm = ($urandom_range(0, 99) == 1);
                step();
                arm = 1'b0;
                abort = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- CPU-side reader for the sample streams the datapath drives toward the DACs, or samples from the ADC/CORDIC taps.
- The datapath writes samples into on-chip memory after a trigger. The CPU arms the block, polls status, then reads the buffer back word by word.
- Sits beside the path-select mux, fed from the selected pair of 16-bit channel samples. Control and status connect to CSRs.

Parameters:
- DW, 16, bits per channel sample (two's complement)
- AW, 10, buffer address width; DEPTH = 2**AW words

Ports:
- sys_clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe; in_ch0/in_ch1 qualified by it
- in_ch0  in  DW  channel 0 sample, signed
- in_ch1  in  DW  channel 1 sample, signed
- arm  in  1  one-cycle pulse; latch config, start waiting for trigger
- abort  in  1  one-cycle pulse; return to IDLE
- trig_mode  in  1  0 = immediate, 1 = rising level crossing on ch0
- trig_level  in  DW  signed threshold for trig_mode 1
- decim  in  8  store one of every decim+1 valid samples
- num_samples  in  AW+1  words to capture; 0 or >DEPTH means DEPTH
- rd_addr  in  AW  CPU read address
- rd_data  out  2*DW  {ch1,ch0} at rd_addr, 1-cycle latency
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- done  out  1  state==DONE
- wr_count  out  AW+1  words written in the current/last capture

Behaviour:
- Reset: state IDLE, wr_count 0, done 0, rd_data 0, decimation counter 0, prev-sample-valid flag 0.
- Reset does not clear the buffer memory.
- arm latches trig_mode, trig_level, decim and num_samples, with num_samples clamped to DEPTH (0 → DEPTH).
- Arm also clears wr_count, the decimation counter and the prev-valid flag, and sets state ARMED.
  - Allowed from any state; in ARMED or CAPTURE it restarts.
- abort in any state → IDLE next cycle. Memory and wr_count are kept.
  - abort and arm in the same cycle: abort wins.
- ARMED:
  - mode 0: first in_valid sample triggers.
  - mode 1: trigger when the prev-valid flag is set and prev_ch0 < trig_level <= in_ch0 (signed compare). prev_ch0 updates on every in_valid in ARMED, and the flag sets on the first one. The first sample after arm can never trigger in mode 1.
  - The trigger sample itself is written at address 0 in the same cycle. State → CAPTURE, wr_count → 1, decimation counter loads decim.
  - If the latched count is 1, state goes directly to DONE.
- CAPTURE, on each in_valid:
  - counter == 0 → write {ch1,ch0} at address wr_count[AW-1:0], increment wr_count, reload counter with decim.
  - Otherwise decrement the counter.
  - When the increment makes wr_count equal the latched count, state → DONE on the same edge.
  - Cycles without in_valid change nothing.
- DONE: hold until arm or abort. No writes occur outside ARMED (trigger sample) and CAPTURE.
- Latency: a sample presented with in_valid at edge N is readable at edge N+1 via rd_addr. rd_data registers mem[rd_addr] each cycle.
- Simultaneous write and read of the same address returns the old contents (read-first).
- wr_count saturates at DEPTH; the address wraps only via the DEPTH case, where final address DEPTH-1 precedes DONE.
- Config inputs changing after arm have no effect until the next arm.

Test Plan:
- Immediate capture, decim 0:
  - Stimulus: trig_mode 0, num_samples 8, arm, then in_valid every cycle with ch0 = 0..9, ch1 = 100..109.
  - Required: DONE after 8 samples, wr_count 8, mem[0..7] = {100+i, i}, mem[8] unchanged.
- Level trigger, decim 0:
  - Stimulus: trig_mode 1, level 0, num_samples 4, ch0 sequence -5, -3, -1, 2, 4, 6, 8.
  - Required: trigger on 2; buffer = 2, 4, 6, 8. A first sample of +7 after arm does not trigger.
- Decimation:
  - Stimulus: decim 2, num_samples 3, mode 0, ch0 = 0..9 with in_valid held low on alternate cycles.
  - Required: mem = 0, 3, 6; DONE only after sample 6.
- Full depth and saturation:
  - Stimulus: num_samples 0, then 2000.
  - Required: both capture exactly DEPTH (1024) words, wr_count 1024, no write past address 1023.
- Abort and arm conflicts:
  - Stimulus: abort mid-CAPTURE at wr_count 5.
  - Required: IDLE, wr_count stays 5, later samples not written.
  - Stimulus: arm and abort in the same cycle. Required: IDLE.
  - Stimulus: arm during CAPTURE. Required: ARMED, wr_count 0.
- Reset mid-capture and read latency:
  - Stimulus: rst during CAPTURE.
  - Required: state 0, done 0, rd_data 0, memory intact.
  - Stimulus: read of rd_addr 3 after reset. Required: the previously captured word is returned one cycle later.
